pe_seq: RTL

- Command-driven sequencer directly upstream of the PE; drives every PE control/data input and collects the PE result.
- Takes LOAD and DOT commands over a valid/ready port and operand beats over a second valid/ready stream.
- Produces the PE act/wgt/store/reuse/addr/finish sequence and returns each dot-product result on a valid/ready result port.

---
 rtl/pe_pkg.sv | 20 ++
 rtl/pe_seq.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/pe_pkg.sv
// Shared state encoding, opcodes and PE regfile address constants for pe_seq.
package pe_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    DOT  = 3'd2,
    FIN  = 3'd3,
    CAP  = 3'd4,
    RESP = 3'd5
  } state_t;

  localparam logic OP_LOAD = 1'b0;
  localparam logic OP_DOT  = 1'b1;

  // Regfile entry 0 is the PE accumulator; weights start at entry 1.
  localparam int ACC_ADDR = 0;
  localparam int WGT_BASE = 1;

endpackage

// File: rtl/pe_seq.sv
// Command-driven sequencer feeding one PE: LOAD writes weights, DOT streams MACs and returns the sum.
// Optional build macro PE_SEQ_PERF_EN adds saturating perf_busy / perf_stall counters.
module pe_seq
  import pe_pkg::*;
#(
  parameter int IN_PRECISION  = 16,
  parameter int OUT_PRECISION = 16,
  parameter int REG_SIZE      = 4,
  parameter int LEN_W         = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic                     cmd_op,
  input  logic                     cmd_reuse,
  input  logic [LEN_W-1:0]         cmd_len,
  input  logic                     dat_valid,
  output logic                     dat_ready,
  input  logic [IN_PRECISION-1:0]  dat_act,
  input  logic [IN_PRECISION-1:0]  dat_wgt,
  output logic [IN_PRECISION-1:0]  pe_act,
  output logic [IN_PRECISION-1:0]  pe_wgt,
  output logic                     pe_store,
  output logic                     pe_reuse,
  output logic [REG_SIZE-1:0]      pe_addr,
  output logic                     pe_finish,
  input  logic [OUT_PRECISION-1:0] pe_out,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [OUT_PRECISION-1:0] res_data,
  output state_t                   dbg_state
`ifdef PE_SEQ_PERF_EN
  ,
  output logic [31:0]              perf_busy,
  output logic [31:0]              perf_stall
`endif
);

  // Handshakes: a transfer happens on a rising clk edge where valid and ready are both high;
  // a producer holds its payload stable while valid is high and ready is low.

  localparam logic [REG_SIZE-1:0] PTR_BASE = REG_SIZE'(WGT_BASE);
  localparam logic [REG_SIZE-1:0] PTR_TOP  = REG_SIZE'(REG_SIZE - 1);
  localparam logic [REG_SIZE-1:0] ACC_A    = REG_SIZE'(ACC_ADDR);

  state_t                   state_q, state_d;
  logic                     reuse_q, reuse_d;
  logic [LEN_W-1:0]         len_q, len_d;
  logic [LEN_W-1:0]         beat_q, beat_d;
  logic [REG_SIZE-1:0]      ptr_q, ptr_d;
  logic [REG_SIZE-1:0]      wcnt_q, wcnt_d;
  logic [OUT_PRECISION-1:0] res_q, res_d;
  logic                     resv_q, resv_d;
  logic                     beat_last;

  assign beat_last = (beat_q == len_q - LEN_W'(1));
  assign res_valid = resv_q;
  assign res_data  = res_q;
  assign dbg_state = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      reuse_q <= 1'b0;
      len_q   <= '0;
      beat_q  <= '0;
      ptr_q   <= PTR_BASE;
      wcnt_q  <= '0;
      res_q   <= '0;
      resv_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      reuse_q <= reuse_d;
      len_q   <= len_d;
      beat_q  <= beat_d;
      ptr_q   <= ptr_d;
      wcnt_q  <= wcnt_d;
      res_q   <= res_d;
      resv_q  <= resv_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    reuse_d   = reuse_q;
    len_d     = len_q;
    beat_d    = beat_q;
    ptr_d     = ptr_q;
    wcnt_d    = wcnt_q;
    res_d     = res_q;
    resv_d    = resv_q;
    cmd_ready = 1'b0;
    dat_ready = 1'b0;
    pe_act    = '0;
    pe_wgt    = '0;
    pe_store  = 1'b0;
    pe_reuse  = 1'b0;
    pe_addr   = ACC_A;
    pe_finish = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Gated by rst_n so cmd_ready reads 0 for the whole reset window.
        cmd_ready = rst_n;
        if (cmd_valid) begin
          reuse_d = cmd_reuse;
          len_d   = cmd_len;
          beat_d  = '0;
          if (cmd_op == OP_LOAD) begin
            wcnt_d = (cmd_len >= LEN_W'(REG_SIZE - 1)) ? PTR_TOP : REG_SIZE'(cmd_len);
            if (cmd_len != '0) state_d = LOAD;
          end else begin
            state_d = (cmd_len == '0) ? FIN : DOT;
          end
        end
      end
      LOAD: begin
        dat_ready = 1'b1;
        if (dat_valid) begin
          pe_store = 1'b1;
          pe_wgt   = dat_wgt;
          pe_addr  = ptr_q;
          ptr_d    = (ptr_q >= PTR_TOP) ? PTR_BASE : ptr_q + REG_SIZE'(1);
          beat_d   = beat_q + LEN_W'(1);
          if (beat_last) begin
            ptr_d   = PTR_BASE;
            state_d = IDLE;
          end
        end
      end
      DOT: begin
        dat_ready = 1'b1;
        if (dat_valid) begin
          pe_act = dat_act;
          if (reuse_q) begin
            pe_reuse = 1'b1;
            pe_addr  = ptr_q;
            // With no loaded weights (wcnt 0) the compare holds the pointer at the base.
            ptr_d    = (ptr_q >= wcnt_q) ? PTR_BASE : ptr_q + REG_SIZE'(1);
          end else begin
            pe_wgt = dat_wgt;
          end
          beat_d = beat_q + LEN_W'(1);
          if (beat_last) state_d = FIN;
        end
      end
      FIN: begin
        pe_finish = 1'b1;
        state_d   = CAP;
      end
      CAP: begin
        res_d   = pe_out;
        resv_d  = 1'b1;
        state_d = RESP;
      end
      RESP: begin
        if (res_ready) begin
          resv_d  = 1'b0;
          ptr_d   = PTR_BASE;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef PE_SEQ_PERF_EN
  logic stall_cyc;
  assign stall_cyc = ((state_q == LOAD || state_q == DOT) && !dat_valid) ||
                     (state_q == RESP && !res_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_busy  <= '0;
      perf_stall <= '0;
    end else begin
      if (state_q != IDLE && perf_busy != '1) perf_busy <= perf_busy + 32'd1;
      if (stall_cyc && perf_stall != '1) perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule
